alu_issue_stage: RTL and testbench

ID/EX issue register that drives the execute-stage ALU. Each cycle it takes one RV32I instruction with its register-file read data, decodes the 4-bit `alu_ctrl`, selects and sign-extends operands, and registers them with pipeline metadata. It uses a valid/ready handshake with flush, so the ALU's combinational `src1`/`src2`/`alu_ctrl` inputs always come from a flop.

---
 rtl/alu_pkg.sv | 64 ++++++
 rtl/alu_dec.sv | 153 +++++++++++++++
 rtl/alu_issue_stage.sv | 168 ++++++++++++++++
 tb/tb_alu_issue_stage.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants for the ALU issue stage: ALU opcodes, RV32I major opcodes,
// immediate formats and operand-select encodings.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLTU = 4'b1001;
    localparam logic [3:0] ALU_XOR  = 4'b1100;
    localparam logic [3:0] ALU_SRL  = 4'b1101;
    localparam logic [3:0] ALU_SLL  = 4'b1110;
    localparam logic [3:0] ALU_SRA  = 4'b1111;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        IMM_NONE  = 3'd0,
        IMM_I     = 3'd1,
        IMM_S     = 3'd2,
        IMM_U     = 3'd3,
        IMM_SHAMT = 3'd4,
        IMM_LINK  = 3'd5
    } imm_fmt_e;

    typedef enum logic [1:0] {
        SRC1_RS1  = 2'd0,
        SRC1_PC   = 2'd1,
        SRC1_ZERO = 2'd2
    } src1_sel_e;

    typedef enum logic [1:0] {
        SRC2_RS2  = 2'd0,
        SRC2_IMM  = 2'd1,
        SRC2_ZERO = 2'd2
    } src2_sel_e;

    // alt selects SUB/SRA on the funct3 codes that have an alternate form
    function automatic logic [3:0] funct3_to_alu(input logic [2:0] f3, input logic alt);
        logic [3:0] code;
        case (f3)
            3'b000:  code = alt ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = alt ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            3'b111:  code = ALU_AND;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/alu_dec.sv
// Combinational RV32I decoder: instruction to ALU code, operand selects,
// immediate and writeback/branch/illegal flags.
module alu_dec
    import alu_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic [3:0]  o_alu_ctrl,
    output src1_sel_e   o_src1_sel,
    output src2_sel_e   o_src2_sel,
    output logic [31:0] o_imm,
    output logic [4:0]  o_rd,
    output logic        o_reg_wen,
    output logic        o_is_branch,
    output logic [2:0]  o_br_funct3,
    output logic        o_illegal
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    logic [3:0] w_ctrl;
    src1_sel_e  w_s1;
    src2_sel_e  w_s2;
    imm_fmt_e   w_fmt;
    logic       w_wen;
    logic       w_br;
    logic       w_ill;

    assign w_opcode = i_instr[6:0];
    assign w_funct3 = i_instr[14:12];
    assign w_funct7 = i_instr[31:25];
    assign o_rd     = i_instr[11:7];

    // Raw decode before the illegal override
    always_comb begin
        w_ctrl = ALU_ADD;
        w_s1   = SRC1_ZERO;
        w_s2   = SRC2_ZERO;
        w_fmt  = IMM_NONE;
        w_wen  = 1'b0;
        w_br   = 1'b0;
        w_ill  = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_s1  = SRC1_RS1;
                w_s2  = SRC2_RS2;
                w_wen = 1'b1;
                if (w_funct7 == 7'b0000000) begin
                    w_ctrl = funct3_to_alu(w_funct3, 1'b0);
                end else if (w_funct7 == 7'b0100000 &&
                             (w_funct3 == 3'b000 || w_funct3 == 3'b101)) begin
                    w_ctrl = funct3_to_alu(w_funct3, 1'b1);
                end else begin
                    w_ill = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                w_s1  = SRC1_RS1;
                w_s2  = SRC2_IMM;
                w_wen = 1'b1;
                if (w_funct3 == 3'b001 || w_funct3 == 3'b101) begin
                    w_fmt = IMM_SHAMT;
                    if (w_funct7 == 7'b0000000) begin
                        w_ctrl = funct3_to_alu(w_funct3, 1'b0);
                    end else if (w_funct7 == 7'b0100000 && w_funct3 == 3'b101) begin
                        w_ctrl = ALU_SRA;
                    end else begin
                        w_ill = 1'b1;
                    end
                end else begin
                    // funct7 bits are immediate bits here, never an alternate-op flag
                    w_fmt  = IMM_I;
                    w_ctrl = funct3_to_alu(w_funct3, 1'b0);
                end
            end
            OPC_LOAD: begin
                w_s1  = SRC1_RS1;
                w_s2  = SRC2_IMM;
                w_fmt = IMM_I;
                w_wen = 1'b1;
            end
            OPC_STORE: begin
                w_s1  = SRC1_RS1;
                w_s2  = SRC2_IMM;
                w_fmt = IMM_S;
            end
            OPC_BRANCH: begin
                w_s1 = SRC1_RS1;
                w_s2 = SRC2_RS2;
                w_br = 1'b1;
                case (w_funct3)
                    3'b000, 3'b001: w_ctrl = ALU_SUB;
                    3'b100, 3'b101: w_ctrl = ALU_SLT;
                    3'b110, 3'b111: w_ctrl = ALU_SLTU;
                    default:        w_ill  = 1'b1;
                endcase
            end
            OPC_LUI: begin
                w_s2  = SRC2_IMM;
                w_fmt = IMM_U;
                w_wen = 1'b1;
            end
            OPC_AUIPC: begin
                w_s1  = SRC1_PC;
                w_s2  = SRC2_IMM;
                w_fmt = IMM_U;
                w_wen = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                w_s1  = SRC1_PC;
                w_s2  = SRC2_IMM;
                w_fmt = IMM_LINK;
                w_wen = 1'b1;
            end
            default: begin
                w_ill = 1'b1;
            end
        endcase
    end

    // Immediate generation by format
    always_comb begin
        case (w_fmt)
            IMM_I:     o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
            IMM_S:     o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            IMM_U:     o_imm = {i_instr[31:12], 12'b0};
            IMM_SHAMT: o_imm = {27'b0, i_instr[24:20]};
            IMM_LINK:  o_imm = 32'd4;
            default:   o_imm = 32'd0;
        endcase
    end

    // Any illegal encoding collapses to a harmless ADD 0,0 with no side effects
    always_comb begin
        if (w_ill) begin
            o_alu_ctrl  = ALU_ADD;
            o_src1_sel  = SRC1_ZERO;
            o_src2_sel  = SRC2_ZERO;
            o_reg_wen   = 1'b0;
            o_is_branch = 1'b0;
            o_br_funct3 = 3'b000;
        end else begin
            o_alu_ctrl  = w_ctrl;
            o_src1_sel  = w_s1;
            o_src2_sel  = w_s2;
            o_reg_wen   = w_wen && (i_instr[11:7] != 5'd0);
            o_is_branch = w_br;
            o_br_funct3 = w_br ? w_funct3 : 3'b000;
        end
        o_illegal = w_ill;
    end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue register feeding the execute-stage ALU with a valid/ready/flush handshake.
// Define ALU_ISSUE_FWD_EN to add EX/MEM and MEM/WB operand forwarding ports.
module alu_issue_stage
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic        flush,
`ifdef ALU_ISSUE_FWD_EN
    input  logic [4:0]  exmem_rd,
    input  logic [4:0]  memwb_rd,
    input  logic        exmem_wen,
    input  logic        memwb_wen,
    input  logic [31:0] exmem_val,
    input  logic [31:0] memwb_val,
`endif
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  alu_ctrl,
    output logic [31:0] src1,
    output logic [31:0] src2,
    output logic [31:0] store_data,
    output logic [4:0]  rd,
    output logic        reg_wen,
    output logic        is_branch,
    output logic [2:0]  br_funct3,
    output logic        illegal
);

    logic [3:0]  w_alu_ctrl;
    src1_sel_e   w_src1_sel;
    src2_sel_e   w_src2_sel;
    logic [31:0] w_imm;
    logic [4:0]  w_rd;
    logic        w_reg_wen;
    logic        w_is_branch;
    logic [2:0]  w_br_funct3;
    logic        w_illegal;
    logic [31:0] w_rs1_val;
    logic [31:0] w_rs2_val;
    logic [31:0] w_src1;
    logic [31:0] w_src2;
    logic        w_load;

    logic        r_out_valid;
    logic [3:0]  r_alu_ctrl;
    logic [31:0] r_src1;
    logic [31:0] r_src2;
    logic [31:0] r_store_data;
    logic [4:0]  r_rd;
    logic        r_reg_wen;
    logic        r_is_branch;
    logic [2:0]  r_br_funct3;
    logic        r_illegal;

    alu_dec u_dec (
        .i_instr     (instr),
        .o_alu_ctrl  (w_alu_ctrl),
        .o_src1_sel  (w_src1_sel),
        .o_src2_sel  (w_src2_sel),
        .o_imm       (w_imm),
        .o_rd        (w_rd),
        .o_reg_wen   (w_reg_wen),
        .o_is_branch (w_is_branch),
        .o_br_funct3 (w_br_funct3),
        .o_illegal   (w_illegal)
    );

`ifdef ALU_ISSUE_FWD_EN
    logic [4:0] w_rs1_idx;
    logic [4:0] w_rs2_idx;
    assign w_rs1_idx = instr[19:15];
    assign w_rs2_idx = instr[24:20];

    // Forwarding: EX/MEM beats MEM/WB, x0 always reads the register file
    always_comb begin
        if (w_rs1_idx == 5'd0) begin
            w_rs1_val = rs1_data;
        end else if (exmem_wen && exmem_rd == w_rs1_idx) begin
            w_rs1_val = exmem_val;
        end else if (memwb_wen && memwb_rd == w_rs1_idx) begin
            w_rs1_val = memwb_val;
        end else begin
            w_rs1_val = rs1_data;
        end
        if (w_rs2_idx == 5'd0) begin
            w_rs2_val = rs2_data;
        end else if (exmem_wen && exmem_rd == w_rs2_idx) begin
            w_rs2_val = exmem_val;
        end else if (memwb_wen && memwb_rd == w_rs2_idx) begin
            w_rs2_val = memwb_val;
        end else begin
            w_rs2_val = rs2_data;
        end
    end
`else
    assign w_rs1_val = rs1_data;
    assign w_rs2_val = rs2_data;
`endif

    // Operand selection ahead of the issue register
    always_comb begin
        case (w_src1_sel)
            SRC1_RS1: w_src1 = w_rs1_val;
            SRC1_PC:  w_src1 = pc;
            default:  w_src1 = 32'd0;
        endcase
        case (w_src2_sel)
            SRC2_RS2: w_src2 = w_rs2_val;
            SRC2_IMM: w_src2 = w_imm;
            default:  w_src2 = 32'd0;
        endcase
    end

    assign in_ready = !r_out_valid || out_ready;
    assign w_load   = in_valid && in_ready && !flush;

    // Issue register: flush beats load, load beats hold, consume empties the slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid  <= 1'b0;
            r_alu_ctrl   <= 4'd0;
            r_src1       <= 32'd0;
            r_src2       <= 32'd0;
            r_store_data <= 32'd0;
            r_rd         <= 5'd0;
            r_reg_wen    <= 1'b0;
            r_is_branch  <= 1'b0;
            r_br_funct3  <= 3'd0;
            r_illegal    <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_out_valid  <= 1'b1;
            r_alu_ctrl   <= w_alu_ctrl;
            r_src1       <= w_src1;
            r_src2       <= w_src2;
            r_store_data <= w_rs2_val;
            r_rd         <= w_rd;
            r_reg_wen    <= w_reg_wen;
            r_is_branch  <= w_is_branch;
            r_br_funct3  <= w_br_funct3;
            r_illegal    <= w_illegal;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= r_out_valid;
        end
    end

    assign out_valid  = r_out_valid;
    assign alu_ctrl   = r_alu_ctrl;
    assign src1       = r_src1;
    assign src2       = r_src2;
    assign store_data = r_store_data;
    assign rd         = r_rd;
    assign reg_wen    = r_reg_wen;
    assign is_branch  = r_is_branch;
    assign br_funct3  = r_br_funct3;
    assign illegal    = r_illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Table-driven bench for alu_issue_stage plus stall, flush, reset and forwarding sequences.
module tb_alu_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_ctrl;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic        reg_wen;
    logic        is_branch;
    logic [2:0]  br_funct3;
    logic        illegal;
`ifdef ALU_ISSUE_FWD_EN
    logic [4:0]  exmem_rd;
    logic [4:0]  memwb_rd;
    logic        exmem_wen;
    logic        memwb_wen;
    logic [31:0] exmem_val;
    logic [31:0] memwb_val;
`endif

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .pc         (pc),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .flush      (flush),
`ifdef ALU_ISSUE_FWD_EN
        .exmem_rd   (exmem_rd),
        .memwb_rd   (memwb_rd),
        .exmem_wen  (exmem_wen),
        .memwb_wen  (memwb_wen),
        .exmem_val  (exmem_val),
        .memwb_val  (memwb_val),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_ctrl   (alu_ctrl),
        .src1       (src1),
        .src2       (src2),
        .store_data (store_data),
        .rd         (rd),
        .reg_wen    (reg_wen),
        .is_branch  (is_branch),
        .br_funct3  (br_funct3),
        .illegal    (illegal)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  ctrl;
        logic [31:0] s1;
        logic [31:0] s2;
        logic [4:0]  rd;
        logic        wen;
        logic        br;
        logic [2:0]  f3;
        logic        ill;
    } vec_t;

    vec_t vecs[$];
    int   n_pass = 0;
    int   n_tot  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic add(input logic [31:0] i, input logic [31:0] p, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] c, input logic [31:0] s1,
                       input logic [31:0] s2, input logic [4:0] r, input logic w,
                       input logic br, input logic [2:0] f3, input logic ill);
        vec_t v;
        v.instr = i; v.pc = p; v.rs1 = a; v.rs2 = b; v.ctrl = c; v.s1 = s1; v.s2 = s2;
        v.rd = r; v.wen = w; v.br = br; v.f3 = f3; v.ill = ill;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b);
        in_valid = 1'b1;
        instr    = i;
        pc       = p;
        rs1_data = a;
        rs2_data = b;
    endtask

    task automatic check_vec(input int n, input vec_t v);
        string t;
        t = $sformatf("v%0d", n);
        chk({t, ".valid"}, {31'd0, out_valid}, 32'd1);
        chk({t, ".ctrl"},  {28'd0, alu_ctrl}, {28'd0, v.ctrl});
        chk({t, ".src1"},  src1, v.s1);
        chk({t, ".src2"},  src2, v.s2);
        chk({t, ".store"}, store_data, v.rs2);
        chk({t, ".rd"},    {27'd0, rd}, {27'd0, v.rd});
        chk({t, ".wen"},   {31'd0, reg_wen}, {31'd0, v.wen});
        chk({t, ".br"},    {31'd0, is_branch}, {31'd0, v.br});
        chk({t, ".f3"},    {29'd0, br_funct3}, {29'd0, v.f3});
        chk({t, ".ill"},   {31'd0, illegal}, {31'd0, v.ill});
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        instr = 32'd0; pc = 32'd0; rs1_data = 32'd0; rs2_data = 32'd0;
`ifdef ALU_ISSUE_FWD_EN
        exmem_rd = 5'd0; memwb_rd = 5'd0; exmem_wen = 1'b0; memwb_wen = 1'b0;
        exmem_val = 32'd0; memwb_val = 32'd0;
`endif
        //   instr         pc          rs1           rs2           ctrl     src1          src2          rd  wen  br  f3     ill
        add(32'h002081B3, 32'h0,     32'd5,        32'd7,        4'b0010, 32'd5,        32'd7,        5'd3,  1'b1, 1'b0, 3'b000, 1'b0);
        add(32'h40208133, 32'h0,     32'd9,        32'd4,        4'b0110, 32'd9,        32'd4,        5'd2,  1'b1, 1'b0, 3'b000, 1'b0);
        add(32'h40335293, 32'h0,     32'h80000000, 32'h11,       4'b1111, 32'h80000000, 32'd3,        5'd5,  1'b1, 1'b0, 3'b000, 1'b0);
        add(32'h00335293, 32'h0,     32'h80000000, 32'h11,       4'b1101, 32'h80000000, 32'd3,        5'd5,  1'b1, 1'b0, 3'b000, 1'b0);
        add(32'h0020E463, 32'h0,     32'd3,        32'd10,       4'b1001, 32'd3,        32'd10,       5'd8,  1'b0, 1'b1, 3'b110, 1'b0);
        add(32'h00208463, 32'h0,     32'd3,        32'd3,        4'b0110, 32'd3,        32'd3,        5'd8,  1'b0, 1'b1, 3'b000, 1'b0);
        add(32'h0020D463, 32'h0,     32'd1,        32'd2,        4'b0111, 32'd1,        32'd2,        5'd8,  1'b0, 1'b1, 3'b101, 1'b0);
        add(32'h0000007F, 32'h0,     32'h55,       32'h66,       4'b0010, 32'd0,        32'd0,        5'd0,  1'b0, 1'b0, 3'b000, 1'b1);
        add(32'h40010093, 32'h0,     32'd100,      32'd0,        4'b0010, 32'd100,      32'h400,      5'd1,  1'b1, 1'b0, 3'b000, 1'b0);
        add(32'hFFF08213, 32'h0,     32'd10,       32'd0,        4'b0010, 32'd10,       32'hFFFFFFFF, 5'd4,  1'b1, 1'b0, 3'b000, 1'b0);
        add(32'h123452B7, 32'h0,     32'd1,        32'd2,        4'b0010, 32'd0,        32'h12345000, 5'd5,  1'b1, 1'b0, 3'b000, 1'b0);
        add(32'h00001317, 32'h100,   32'd1,        32'd2,        4'b0010, 32'h100,      32'h1000,     5'd6,  1'b1, 1'b0, 3'b000, 1'b0);
        add(32'h008000EF, 32'h200,   32'd1,        32'd2,        4'b0010, 32'h200,      32'd4,        5'd1,  1'b1, 1'b0, 3'b000, 1'b0);
        add(32'h000100E7, 32'h300,   32'd1,        32'd2,        4'b0010, 32'h300,      32'd4,        5'd1,  1'b1, 1'b0, 3'b000, 1'b0);
        add(32'h00208423, 32'h0,     32'h1000,     32'hDEAD,     4'b0010, 32'h1000,     32'd8,        5'd8,  1'b0, 1'b0, 3'b000, 1'b0);
        add(32'hFE208E23, 32'h0,     32'h1000,     32'hBEEF,     4'b0010, 32'h1000,     32'hFFFFFFFC, 5'd28, 1'b0, 1'b0, 3'b000, 1'b0);
        add(32'hFF80A383, 32'h0,     32'h2000,     32'd0,        4'b0010, 32'h2000,     32'hFFFFFFF8, 5'd7,  1'b1, 1'b0, 3'b000, 1'b0);
        add(32'h00208033, 32'h0,     32'd1,        32'd2,        4'b0010, 32'd1,        32'd2,        5'd0,  1'b0, 1'b0, 3'b000, 1'b0);
        add(32'h0020A1B3, 32'h0,     32'd1,        32'd2,        4'b0111, 32'd1,        32'd2,        5'd3,  1'b1, 1'b0, 3'b000, 1'b0);
        add(32'h0020C1B3, 32'h0,     32'd1,        32'd2,        4'b1100, 32'd1,        32'd2,        5'd3,  1'b1, 1'b0, 3'b000, 1'b0);
        add(32'h0020F1B3, 32'h0,     32'd1,        32'd2,        4'b0000, 32'd1,        32'd2,        5'd3,  1'b1, 1'b0, 3'b000, 1'b0);
        add(32'h002091B3, 32'h0,     32'd1,        32'd2,        4'b1110, 32'd1,        32'd2,        5'd3,  1'b1, 1'b0, 3'b000, 1'b0);
        add(32'h4020F1B3, 32'h0,     32'd1,        32'd2,        4'b0010, 32'd0,        32'd0,        5'd3,  1'b0, 1'b0, 3'b000, 1'b1);
        add(32'h0020A463, 32'h0,     32'd1,        32'd2,        4'b0010, 32'd0,        32'd0,        5'd8,  1'b0, 1'b0, 3'b000, 1'b1);
        add(32'h40309293, 32'h0,     32'd1,        32'd2,        4'b0010, 32'd0,        32'd0,        5'd5,  1'b0, 1'b0, 3'b000, 1'b1);

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.valid", {31'd0, out_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst.valid2", {31'd0, out_valid}, 32'd0);
        chk("rst.ready",  {31'd0, in_ready}, 32'd1);
        chk("rst.ctrl",   {28'd0, alu_ctrl}, 32'd0);
        chk("rst.src1",   src1, 32'd0);
        chk("rst.wen",    {31'd0, reg_wen}, 32'd0);

        // Back-to-back table with out_ready held high: one result per cycle
        out_ready = 1'b1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].instr, vecs[i].pc, vecs[i].rs1, vecs[i].rs2);
            @(negedge clk);
            check_vec(i, vecs[i]);
            chk($sformatf("v%0d.in_ready", i), {31'd0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("drain.valid", {31'd0, out_valid}, 32'd0);

        // Stall: ADD held for three cycles while SUB waits upstream
        drive(32'h002081B3, 32'h0, 32'd5, 32'd7);
        @(negedge clk);
        chk("stall.a_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b0;
        drive(32'h40208133, 32'h0, 32'd9, 32'd4);
        #1 chk("stall.ready0", {31'd0, in_ready}, 32'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("stall%0d.valid", k), {31'd0, out_valid}, 32'd1);
            chk($sformatf("stall%0d.ctrl", k),  {28'd0, alu_ctrl}, 32'h2);
            chk($sformatf("stall%0d.src1", k),  src1, 32'd5);
            chk($sformatf("stall%0d.rd", k),    {27'd0, rd}, 32'd3);
            chk($sformatf("stall%0d.ready", k), {31'd0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        #1 chk("stall.ready1", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        chk("stall.b_valid", {31'd0, out_valid}, 32'd1);
        chk("stall.b_ctrl",  {28'd0, alu_ctrl}, 32'h6);
        chk("stall.b_src1",  src1, 32'd9);
        chk("stall.b_rd",    {27'd0, rd}, 32'd2);
        in_valid = 1'b0;
        @(negedge clk);
        chk("stall.empty", {31'd0, out_valid}, 32'd0);

        // Flush a held slot while a new instruction is offered
        drive(32'h002081B3, 32'h0, 32'd5, 32'd7);
        @(negedge clk);
        chk("flush.a_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b0;
        drive(32'h40208133, 32'h0, 32'd9, 32'd4);
        flush = 1'b1;
        @(negedge clk);
        chk("flush.valid", {31'd0, out_valid}, 32'd0);
        flush = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("flush.b_valid", {31'd0, out_valid}, 32'd1);
        chk("flush.b_ctrl",  {28'd0, alu_ctrl}, 32'h6);
        chk("flush.b_src1",  src1, 32'd9);
        in_valid = 1'b0;
        @(negedge clk);

        // Flush with an empty slot and out_ready high still blocks the load
        drive(32'h002081B3, 32'h0, 32'd5, 32'd7);
        flush = 1'b1;
        @(negedge clk);
        chk("flush2.valid", {31'd0, out_valid}, 32'd0);
        flush = 1'b0;
        in_valid = 1'b0;

`ifdef ALU_ISSUE_FWD_EN
        // EX/MEM wins over MEM/WB on rs1
        drive(32'h002081B3, 32'h0, 32'd5, 32'd7);
        exmem_rd = 5'd1; exmem_wen = 1'b1; exmem_val = 32'h10;
        memwb_rd = 5'd1; memwb_wen = 1'b1; memwb_val = 32'h20;
        @(negedge clk);
        chk("fwd.exmem_src1", src1, 32'h10);
        chk("fwd.exmem_src2", src2, 32'd7);
        // MEM/WB only on rs2, reaching both src2 and store_data
        exmem_rd = 5'd5; memwb_rd = 5'd2; memwb_val = 32'h99;
        @(negedge clk);
        chk("fwd.memwb_src1",  src1, 32'd5);
        chk("fwd.memwb_src2",  src2, 32'h99);
        chk("fwd.memwb_store", store_data, 32'h99);
        // x0 source never forwarded
        drive(32'h00500093, 32'h0, 32'h33, 32'd0);
        exmem_rd = 5'd0; exmem_wen = 1'b1; exmem_val = 32'hBAD;
        memwb_rd = 5'd0; memwb_wen = 1'b1; memwb_val = 32'hBAD;
        @(negedge clk);
        chk("fwd.x0_src1", src1, 32'h33);
        chk("fwd.x0_src2", src2, 32'd5);
        exmem_wen = 1'b0; memwb_wen = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
`endif

        // Asynchronous reset in the middle of a stall drops the held instruction
        drive(32'h002081B3, 32'h0, 32'd5, 32'd7);
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("rst_mid.held", {31'd0, out_valid}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid.valid", {31'd0, out_valid}, 32'd0);
        chk("rst_mid.src1",  src1, 32'd0);
        chk("rst_mid.ctrl",  {28'd0, alu_ctrl}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid.after", {31'd0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
